// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: synchronizes pwm_in, measures high time and rise-to-rise period,
// and reports constant-level inputs through a timeout path.
module pwm_duty_decoder #(
  parameter int DATA_W = 12,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [DATA_W-1:0] duty_count,
  output logic [DATA_W-1:0] period_count,
  output logic              valid,
  output logic              timeout
);

  typedef enum logic {SYNC, MEAS} state_t;

  localparam logic [DATA_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_W-1:0] CNT_ONE = 1;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [STAGES-1:0] sync_p0;
  logic              prev_p1;
  logic              s;
  logic              rise;
  logic              tmo;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] high_cnt, per_cnt;
  logic [DATA_W-1:0] high_nxt, per_nxt;
  logic              rpt, rpt_tmo;
  logic [DATA_W-1:0] rpt_duty, rpt_per;

  // Stage p0/p1: synchronizer and edge detect, preset high so only a seen low arms a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '1;
      prev_p1 <= 1'b1;
    end else begin
      sync_p0 <= {sync_p0[STAGES-2:0], pwm_in};
      prev_p1 <= sync_p0[STAGES-1];
    end
  end

  assign s    = sync_p0[STAGES-1];
  assign rise = s & ~prev_p1;
  assign tmo  = (per_cnt == CNT_MAX) && !rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable)   state_nxt = SYNC;
    else if (rise) state_nxt = MEAS;
    else if (tmo)  state_nxt = SYNC;
  end

  // A rise beats a simultaneous timeout, so the counters never wrap
  always_comb begin
    high_nxt = high_cnt;
    per_nxt  = per_cnt;
    rpt      = 1'b0;
    rpt_tmo  = 1'b0;
    rpt_duty = high_cnt;
    rpt_per  = per_cnt;
    if (!enable) begin
      high_nxt = '0;
      per_nxt  = '0;
    end else if (rise) begin
      high_nxt = CNT_ONE;
      per_nxt  = CNT_ONE;
      rpt      = (state == MEAS);
    end else if (tmo) begin
      high_nxt = '0;
      per_nxt  = '0;
      rpt      = 1'b1;
      rpt_tmo  = 1'b1;
      rpt_duty = s ? CNT_MAX : '0;
      rpt_per  = CNT_MAX;
    end else begin
      per_nxt = sat_inc(per_cnt);
      if (state == SYNC)  high_nxt = '0;
      else if (s)         high_nxt = sat_inc(high_cnt);
    end
  end

  // Stage p2: counters and registered report
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt     <= '0;
      per_cnt      <= '0;
      duty_count   <= '0;
      period_count <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      high_cnt <= high_nxt;
      per_cnt  <= per_nxt;
      valid    <= rpt;
      if (rpt) begin
        duty_count   <= rpt_duty;
        period_count <= rpt_per;
        timeout      <= rpt_tmo;
      end
    end
  end

endmodule
